// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Hazard and sequencing control for a 5-stage pipeline. Drives
//                the PC / pipeline-register enables and flushes for load-use
//                stalls, branch and jump flushes, data-memory freezes and a
//                debug halt/drain. It also keeps saturating stall and flush
//                counters and a sticky memory-timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int CNT_W        = 32,
    parameter int MAX_WAIT     = 64,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [1:0]       idex_mem_read_i,
    input  logic [4:0]       idex_reg_write_addr_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             exmem_branch_i,
    input  logic             exmem_zero_i,
    input  logic             id_jump_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    input  logic             halt_req_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic             pipe_write_o,
    output logic             halted_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int DRN_W  = $clog2(DRAIN_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [DRN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic freeze;
    logic taken;
    logic lu;

    assign freeze = mem_req_i & ~mem_ready_i;
    assign taken  = exmem_branch_i & exmem_zero_i;
    // A load in EX whose destination feeds the ID instruction; r0 never hazards.
    assign lu     = (idex_mem_read_i != 2'b00) && (idex_reg_write_addr_i != 5'd0) &&
                    ((idex_reg_write_addr_i == ifid_rs_i) ||
                     (ifid_uses_rt_i && (idex_reg_write_addr_i == ifid_rt_i)));

    // State, counters and flags register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            drain_cnt_q <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic for the FSM, drain/wait counters and performance counters.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        wait_cnt_d  = '0;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        // Freeze run length saturates at the limit; the flag stays sticky.
        if (freeze) begin
            wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_d == WAIT_LIMIT) begin
                timeout_d = 1'b1;
            end
        end

        // A frozen cycle outranks a taken branch, so it is not a flush cycle.
        if (taken && !freeze && state_q != ST_HALTED && flush_cnt_q != {CNT_W{1'b1}}) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end

        if (state_q == ST_RUN && (freeze || (lu && !taken)) && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_RUN: begin
                drain_cnt_d = '0;
                if (halt_req_i && !freeze && !taken) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!halt_req_i) begin
                    state_d     = ST_RUN;
                    drain_cnt_d = '0;
                end else if (!freeze) begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d     = ST_HALTED;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DRN_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                if (!halt_req_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d     = ST_RUN;
                drain_cnt_d = '0;
            end
        endcase
    end

    // Pipeline enables and flushes decoded from the state and this cycle's hazards.
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        pipe_write_o  = 1'b1;
        halted_o      = 1'b0;

        if (!reset_i) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            pipe_write_o = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (freeze) begin
                        pc_write_o   = 1'b0;
                        ifid_write_o = 1'b0;
                        pipe_write_o = 1'b0;
                    end else if (taken) begin
                        ifid_flush_o  = 1'b1;
                        idex_flush_o  = 1'b1;
                        exmem_flush_o = 1'b1;
                    end else if (lu) begin
                        // The bubble moves the load out of EX, so the hazard clears itself.
                        pc_write_o   = 1'b0;
                        ifid_write_o = 1'b0;
                        idex_flush_o = 1'b1;
                    end else if (id_jump_i) begin
                        ifid_flush_o = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // IF/ID is held so execution resumes with the same instruction.
                    pc_write_o   = 1'b0;
                    ifid_write_o = 1'b0;
                    idex_flush_o = 1'b1;
                    pipe_write_o = ~freeze;
                    if (taken && !freeze) begin
                        pc_write_o    = 1'b1;
                        ifid_flush_o  = 1'b1;
                        exmem_flush_o = 1'b1;
                    end
                end
                default: begin
                    pc_write_o   = 1'b0;
                    ifid_write_o = 1'b0;
                    pipe_write_o = 1'b0;
                    halted_o     = 1'b1;
                end
            endcase
        end
    end

    assign mem_timeout_o = timeout_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Directed self-checking bench for pipeline_hazard_ctrl. A
//                default-parameter instance and a small one (CNT_W=4,
//                MAX_WAIT=4) share the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] idex_mem_read;
    logic [4:0] idex_rd, ifid_rs, ifid_rt;
    logic       uses_rt, branch, zero, jump, mem_req, mem_ready, halt_req;

    logic        pcw_m, ifw_m, iff_m, ief_m, emf_m, pw_m, hlt_m, to_m;
    logic [31:0] stall_m, flush_m;
    logic        pcw_s, ifw_s, iff_s, ief_s, emf_s, pw_s, hlt_s, to_s;
    logic [3:0]  stall_s, flush_s;

    logic [6:0] ctl_m;
    assign ctl_m = {pcw_m, ifw_m, iff_m, ief_m, emf_m, pw_m, hlt_m};

    // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_write, halted}
    localparam logic [6:0] C_NORM  = 7'b1100010;
    localparam logic [6:0] C_FRZ   = 7'b0000000;
    localparam logic [6:0] C_TAKEN = 7'b1111110;
    localparam logic [6:0] C_LU    = 7'b0001010;
    localparam logic [6:0] C_JUMP  = 7'b1110010;
    localparam logic [6:0] C_DRN   = 7'b0001010;
    localparam logic [6:0] C_DRNF  = 7'b0001000;
    localparam logic [6:0] C_DRNT  = 7'b1011110;
    localparam logic [6:0] C_HALT  = 7'b0000001;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl dut_m (
        .clk_i(clk), .reset_i(reset), .idex_mem_read_i(idex_mem_read),
        .idex_reg_write_addr_i(idex_rd), .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt),
        .ifid_uses_rt_i(uses_rt), .exmem_branch_i(branch), .exmem_zero_i(zero),
        .id_jump_i(jump), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .halt_req_i(halt_req), .pc_write_o(pcw_m), .ifid_write_o(ifw_m),
        .ifid_flush_o(iff_m), .idex_flush_o(ief_m), .exmem_flush_o(emf_m),
        .pipe_write_o(pw_m), .halted_o(hlt_m), .mem_timeout_o(to_m),
        .stall_cnt_o(stall_m), .flush_cnt_o(flush_m)
    );

    pipeline_hazard_ctrl #(.CNT_W(4), .MAX_WAIT(4), .DRAIN_CYCLES(3)) dut_s (
        .clk_i(clk), .reset_i(reset), .idex_mem_read_i(idex_mem_read),
        .idex_reg_write_addr_i(idex_rd), .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt),
        .ifid_uses_rt_i(uses_rt), .exmem_branch_i(branch), .exmem_zero_i(zero),
        .id_jump_i(jump), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .halt_req_i(halt_req), .pc_write_o(pcw_s), .ifid_write_o(ifw_s),
        .ifid_flush_o(iff_s), .idex_flush_o(ief_s), .exmem_flush_o(emf_s),
        .pipe_write_o(pw_s), .halted_o(hlt_s), .mem_timeout_o(to_s),
        .stall_cnt_o(stall_s), .flush_cnt_o(flush_s)
    );

    always #5 clk = ~clk;

    task automatic idle();
        idex_mem_read = 2'b00; idex_rd = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        uses_rt = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1; halt_req = 1'b0;
    endtask

    // Entered and left just after a falling edge.
    task automatic do_reset();
        idle();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        mem_req = 1'b1; mem_ready = 1'b0; halt_req = 1'b1; branch = 1'b1; zero = 1'b1;
        #1;
        checks++; if (ctl_m !== C_FRZ) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl_m, C_FRZ); end
        @(negedge clk);
        checks++; if (stall_m !== 32'd0 || flush_m !== 32'd0 || to_m !== 1'b0) begin
            failures++; $display("FAIL reset_regs stall=%0d flush=%0d to=%b exp=0,0,0", stall_m, flush_m, to_m); end
        idle();
        reset = 1'b1;
        #1;
        checks++; if (ctl_m !== C_NORM) begin failures++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl_m, C_NORM); end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        do_reset();
        // lw r5 in EX, add r1,r5,r2 in ID
        idex_mem_read = 2'b01; idex_rd = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd2; uses_rt = 1'b1;
        #1;
        checks++; if (ctl_m !== C_LU) begin failures++; $display("FAIL lu_rs_ctl got=%b exp=%b", ctl_m, C_LU); end
        @(negedge clk);
        idex_mem_read = 2'b00; idex_rd = 5'd0;   // bubble now in EX
        #1;
        checks++; if (ctl_m !== C_NORM) begin failures++; $display("FAIL lu_after_bubble got=%b exp=%b", ctl_m, C_NORM); end
        checks++; if (stall_m !== 32'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_m); end
        @(negedge clk);
        // destination r0 never stalls
        idex_mem_read = 2'b10; idex_rd = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        #1;
        checks++; if (ctl_m !== C_NORM) begin failures++; $display("FAIL lu_r0_ctl got=%b exp=%b", ctl_m, C_NORM); end
        @(negedge clk);
        // rt match ignored when rt is not read
        idex_rd = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7; uses_rt = 1'b0;
        #1;
        checks++; if (ctl_m !== C_NORM) begin failures++; $display("FAIL lu_rt_unused got=%b exp=%b", ctl_m, C_NORM); end
        @(negedge clk);
        uses_rt = 1'b1;
        #1;
        checks++; if (ctl_m !== C_LU) begin failures++; $display("FAIL lu_rt_ctl got=%b exp=%b", ctl_m, C_LU); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (stall_m !== 32'd2) begin failures++; $display("FAIL lu_stall_total got=%0d exp=2", stall_m); end
        @(negedge clk);
    endtask

    task automatic test_taken_and_jump();
        do_reset();
        idex_mem_read = 2'b01; idex_rd = 5'd5; ifid_rs = 5'd5; branch = 1'b1; zero = 1'b1;
        #1;
        checks++; if (ctl_m !== C_TAKEN) begin failures++; $display("FAIL taken_lu_ctl got=%b exp=%b", ctl_m, C_TAKEN); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (flush_m !== 32'd1 || stall_m !== 32'd0) begin
            failures++; $display("FAIL taken_lu_cnts flush=%0d stall=%0d exp=1,0", flush_m, stall_m); end
        // branch not taken when zero is low
        branch = 1'b1;
        #1;
        checks++; if (ctl_m !== C_NORM) begin failures++; $display("FAIL branch_nottaken got=%b exp=%b", ctl_m, C_NORM); end
        @(negedge clk);
        idle();
        jump = 1'b1;
        #1;
        checks++; if (ctl_m !== C_JUMP) begin failures++; $display("FAIL jump_ctl got=%b exp=%b", ctl_m, C_JUMP); end
        @(negedge clk);
        idex_mem_read = 2'b01; idex_rd = 5'd9; ifid_rs = 5'd9;
        #1;
        checks++; if (ctl_m !== C_LU) begin failures++; $display("FAIL jump_lu_ctl got=%b exp=%b", ctl_m, C_LU); end
        @(negedge clk);
        idex_mem_read = 2'b00; idex_rd = 5'd0;
        #1;
        checks++; if (ctl_m !== C_JUMP) begin failures++; $display("FAIL jump_after_bubble got=%b exp=%b", ctl_m, C_JUMP); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_freeze();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (ctl_m !== C_FRZ) begin failures++; $display("FAIL freeze_ctl cyc=%0d got=%b exp=%b", i, ctl_m, C_FRZ); end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        checks++; if (ctl_m !== C_NORM) begin failures++; $display("FAIL freeze_release got=%b exp=%b", ctl_m, C_NORM); end
        checks++; if (stall_m !== 32'd5 || stall_s !== 4'd5) begin
            failures++; $display("FAIL freeze_stall_cnt got=%0d/%0d exp=5/5", stall_m, stall_s); end
        checks++; if (to_m !== 1'b0) begin failures++; $display("FAIL freeze_timeout_m got=%b exp=0", to_m); end
        checks++; if (to_s !== 1'b1) begin failures++; $display("FAIL freeze_timeout_s got=%b exp=1", to_s); end
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        checks++; if (to_s !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", to_s); end
        @(negedge clk);
    endtask

    task automatic test_halt();
        do_reset();
        halt_req = 1'b1;
        #1;
        checks++; if (ctl_m !== C_NORM) begin failures++; $display("FAIL halt_run_ctl got=%b exp=%b", ctl_m, C_NORM); end
        @(negedge clk);
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        checks++; if (ctl_m !== C_DRNF) begin failures++; $display("FAIL drain_frozen got=%b exp=%b", ctl_m, C_DRNF); end
        @(negedge clk);
        mem_req = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctl_m !== C_DRN) begin failures++; $display("FAIL drain_ctl cyc=%0d got=%b exp=%b", i, ctl_m, C_DRN); end
            @(negedge clk);
        end
        #1;
        checks++; if (ctl_m !== C_HALT) begin failures++; $display("FAIL halted_ctl got=%b exp=%b", ctl_m, C_HALT); end
        checks++; if (stall_m !== 32'd0) begin failures++; $display("FAIL drain_stall_cnt got=%0d exp=0", stall_m); end
        @(negedge clk);
        halt_req = 1'b0;
        #1;
        checks++; if (ctl_m !== C_HALT) begin failures++; $display("FAIL halt_drop_ctl got=%b exp=%b", ctl_m, C_HALT); end
        @(negedge clk);
        #1;
        checks++; if (ctl_m !== C_NORM) begin failures++; $display("FAIL resume_ctl got=%b exp=%b", ctl_m, C_NORM); end
        @(negedge clk);
    endtask

    task automatic test_drain_taken();
        do_reset();
        halt_req = 1'b1; branch = 1'b1; zero = 1'b1;
        #1;
        checks++; if (ctl_m !== C_TAKEN) begin failures++; $display("FAIL halt_taken_ctl got=%b exp=%b", ctl_m, C_TAKEN); end
        @(negedge clk);
        branch = 1'b0; zero = 1'b0;
        #1;
        checks++; if (ctl_m !== C_NORM) begin failures++; $display("FAIL halt_deferred got=%b exp=%b", ctl_m, C_NORM); end
        @(negedge clk);
        branch = 1'b1; zero = 1'b1;
        #1;
        checks++; if (ctl_m !== C_DRNT) begin failures++; $display("FAIL drain_taken_ctl got=%b exp=%b", ctl_m, C_DRNT); end
        @(negedge clk);
        branch = 1'b0; zero = 1'b0; halt_req = 1'b0;
        #1;
        checks++; if (ctl_m !== C_DRN) begin failures++; $display("FAIL drain_cancel_ctl got=%b exp=%b", ctl_m, C_DRN); end
        checks++; if (flush_m !== 32'd2) begin failures++; $display("FAIL drain_flush_cnt got=%0d exp=2", flush_m); end
        @(negedge clk);
        #1;
        checks++; if (ctl_m !== C_NORM) begin failures++; $display("FAIL drain_cancel_run got=%b exp=%b", ctl_m, C_NORM); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        halt_req = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (ctl_m !== C_DRN) begin failures++; $display("FAIL mid_drain_state got=%b exp=%b", ctl_m, C_DRN); end
        reset = 1'b0;
        #1;
        checks++; if (ctl_m !== C_FRZ) begin failures++; $display("FAIL mid_drain_reset_ctl got=%b exp=%b", ctl_m, C_FRZ); end
        @(negedge clk);
        reset = 1'b1; halt_req = 1'b0;
        #1;
        checks++; if (ctl_m !== C_NORM) begin failures++; $display("FAIL mid_drain_run got=%b exp=%b", ctl_m, C_NORM); end
        @(negedge clk);
    endtask

    task automatic test_saturate();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 20; i++) @(negedge clk);
        mem_ready = 1'b1;
        #1;
        checks++; if (stall_s !== 4'd15) begin failures++; $display("FAIL sat_stall_s got=%0d exp=15", stall_s); end
        checks++; if (stall_m !== 32'd20) begin failures++; $display("FAIL sat_stall_m got=%0d exp=20", stall_m); end
        @(negedge clk);
        // reset in the middle of a freeze clears the flag and counters
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (to_s !== 1'b0 || stall_s !== 4'd0) begin
            failures++; $display("FAIL freeze_reset to=%b stall=%0d exp=0,0", to_s, stall_s); end
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_taken_and_jump();
        test_freeze();
        test_halt();
        test_drain_taken();
        test_reset_mid_drain();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
